// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// default timing parameters and the row/column -> hex keymap.
package keypad_pkg;

    localparam int SCAN_DIV_DEF        = 48000;
    localparam int DEBOUNCE_CYCLES_DEF = 960000;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    // Indexed KEYMAP[row][col]; ascending ranges so the literal reads row0 col0 first.
    localparam logic [0:3][0:3][3:0] KEYMAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle.
//   rows      : active-low row sense lines (from the keypad)
//   cols      : active-low column drive, one bit low at a time
//   key_code  : hex value of the last accepted key
//   key_valid : one-cycle pulse on key acceptance
//   key_held  : high while the accepted key is still pressed
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input rows, output cols, output key_code, output key_valid, output key_held);
    modport slave  (output rows, input cols, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows.
//   clk, reset : clock, async active-high reset (outputs reset to all-ones = idle rows)
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module sync_2ff (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce.
//   clk, reset : clock, async active-high reset
//   kp         : keypad pins and key report (see keypad_scanner_if)
// Columns are walked one at a time; a low row on the last dwell cycle of a
// column freezes the scan and starts debouncing that single (row, col) key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic [3:0]       rows_s;
    logic             any_low;
    logic             row_low;
    logic [1:0]       low_idx;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.rows),
        .q     (rows_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        any_low = ~&rows_s;
        row_low = ~rows_s[row_q];
        // Descending walk so the lowest low row index wins.
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) low_idx = 2'(i);
        end

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    cnt_d = '0;
                    if (any_low) begin
                        row_d   = low_idx;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_low) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt_d       = '0;
                        state_d     = ST_HELD;
                        key_code_d  = KEYMAP[row_q][col_q];
                        key_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce: abandon this key and carry on with the next column.
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (!row_low) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!row_low) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SCAN;
            end
        endcase
    end

    assign kp.cols      = ~(4'b0001 << col_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A keypad matrix model pulls row r low whenever key (r,c) is pressed and
// column c is driven low.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic reset;
    logic [3:0][3:0] pressed;   // pressed[row][col]
    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [3:0] r_v;
        r_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !kp.cols[c]) r_v[r] = 1'b0;
        kp.rows = r_v;
    end

    always @(negedge clk) if (kp.key_valid === 1'b1) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Leaves reset released just after a negedge; the next posedge is edge 1.
    task automatic do_reset();
        reset   = 1'b1;
        pressed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for a key_valid pulse, then confirms it lasts a single cycle.
    task automatic wait_valid(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_pulse_seen"}, 32'(got), 32'd1);
        if (got) begin
            @(negedge clk);
            chk({tag, "_pulse_width"}, 32'(kp.key_valid), 32'd0);
        end
    endtask

    task automatic wait_release(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (kp.key_held === 1'b0) done = 1'b1;
        end
        chk({tag, "_released"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_cols [5];
        int p0;
        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset state and free-running scan.
        reset = 1'b1;
        pressed = '0;
        #12;
        chk("rst_cols", 32'(kp.cols), 32'hE);
        chk("rst_code", 32'(kp.key_code), 32'h0);
        chk("rst_valid", 32'(kp.key_valid), 32'h0);
        chk("rst_held", 32'(kp.key_held), 32'h0);
        do_reset();
        p0 = n_pulse;
        chk("scan_c0", 32'(kp.cols), 32'(exp_cols[0]));
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(posedge clk);
            #1 chk($sformatf("scan_step%0d", i), 32'(kp.cols), 32'(exp_cols[i]));
        end
        repeat (16) @(posedge clk);
        #1 chk("scan_no_valid", 32'(n_pulse - p0), 32'd0);

        // Key '6' (row1/col2): accept, hold, debounced release.
        do_reset();
        p0 = n_pulse;
        pressed[1][2] = 1'b1;
        wait_valid("k6", 100);
        chk("k6_code", 32'(kp.key_code), 32'h6);
        chk("k6_held", 32'(kp.key_held), 32'd1);
        chk("k6_cols_frozen", 32'(kp.cols), 32'hB);
        repeat (12) @(posedge clk);
        #1 pressed = '0;
        repeat (10) @(posedge clk);
        #1 chk("k6_held_late", 32'(kp.key_held), 32'd1);
        @(posedge clk);
        #1 chk("k6_held_drop", 32'(kp.key_held), 32'd0);
        chk("k6_next_col", 32'(kp.cols), 32'h7);
        chk("k6_code_kept", 32'(kp.key_code), 32'h6);
        chk("k6_one_pulse", 32'(n_pulse - p0), 32'd1);

        // Short press on row0/col0: bounce rejected, scan moves to column 1.
        do_reset();
        p0 = n_pulse;
        pressed[0][0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 pressed = '0;
        repeat (4) @(posedge clk);
        #1 chk("bounce_cols", 32'(kp.cols), 32'hD);
        chk("bounce_held", 32'(kp.key_held), 32'd0);
        chk("bounce_no_valid", 32'(n_pulse - p0), 32'd0);
        chk("bounce_code", 32'(kp.key_code), 32'h0);

        // Key 'D' (row3/col3) with a short release glitch.
        do_reset();
        p0 = n_pulse;
        pressed[3][3] = 1'b1;
        wait_valid("kD", 100);
        chk("kD_code", 32'(kp.key_code), 32'hD);
        @(posedge clk);
        #1 pressed = '0;
        repeat (3) @(posedge clk);
        #1 pressed[3][3] = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("kD_glitch_held", 32'(kp.key_held), 32'd1);
        chk("kD_glitch_code", 32'(kp.key_code), 32'hD);
        chk("kD_one_pulse", 32'(n_pulse - p0), 32'd1);
        pressed = '0;
        wait_release("kD", 30);

        // Rows 1 and 2 both low on column 0: row 1 wins.
        do_reset();
        pressed[1][0] = 1'b1;
        pressed[2][0] = 1'b1;
        wait_valid("multi", 100);
        chk("multi_code", 32'(kp.key_code), 32'h4);
        pressed = '0;
        wait_release("multi", 30);

        // Reset while HELD on key '2' (row0/col1).
        do_reset();
        pressed[0][1] = 1'b1;
        wait_valid("k2", 100);
        chk("k2_code", 32'(kp.key_code), 32'h2);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("hrst_cols", 32'(kp.cols), 32'hE);
        chk("hrst_held", 32'(kp.key_held), 32'd0);
        chk("hrst_code", 32'(kp.key_code), 32'h0);
        chk("hrst_valid", 32'(kp.key_valid), 32'd0);
        pressed = '0;
        p0 = n_pulse;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("hrst_restart_c0", 32'(kp.cols), 32'hE);
        repeat (3) @(posedge clk);
        #1 chk("hrst_restart_c1", 32'(kp.cols), 32'hD);
        repeat (30) @(posedge clk);
        #1 chk("hrst_no_valid", 32'(n_pulse - p0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
